// File: rtl/frame_ram_writer.sv
// ----------------------------------------------------------------------------
// frame_ram_writer
//
// Write-side controller for the WORDS x WIDTH frame RAM. It packs a camera
// stream of PIX_W-bit pixels into WIDTH-bit words (WIDTH/PIX_W lanes, first
// pixel in the LSBs) and drives the RAM write port over word addresses
// 0..WORDS-1 for one frame. A fill engine can also clear the whole RAM to one
// colour. The display side reads the RAM through its own port and is not
// touched here.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   enable       gates acceptance of frame_start / clear_req only
//   frame_start  one-cycle pulse marking pixel 0 of a frame
//   pix_valid    pix_data valid this cycle
//   pix_data     pixel value (RGB332)
//   clear_req    request a full-RAM fill with clear_val
//   clear_val    fill pixel, latched when clear_req is accepted
//   we, a, di    registered RAM write port
//   busy         high while capturing or clearing
//   frame_done   pulse coincident with the final capture write
//   short_frame  pulse when a frame is aborted by a new frame_start
//   overrun      sticky: pixels arrived after a completed frame
// ----------------------------------------------------------------------------
module frame_ram_writer #(
  parameter int WORDS = 4800,
  parameter int DEPTH = 13,
  parameter int WIDTH = 128,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             clear_req,
  input  logic [PIX_W-1:0] clear_val,
  output logic             we,
  output logic [DEPTH-1:0] a,
  output logic [WIDTH-1:0] di,
  output logic             busy,
  output logic             frame_done,
  output logic             short_frame,
  output logic             overrun
);

  localparam int LANES = WIDTH / PIX_W;
  localparam int LW    = $clog2(LANES);

  localparam logic [DEPTH-1:0] LAST_WORD = DEPTH'(WORDS - 1);
  localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CLEAR
  } state_t;

  state_t           state_q,       state_d;
  logic [DEPTH-1:0] wcnt_q,        wcnt_d;
  logic [LW-1:0]    pixcnt_q,      pixcnt_d;
  logic [WIDTH-1:0] pack_q,        pack_d;
  logic [PIX_W-1:0] clear_val_q,   clear_val_d;
  logic             done_seen_q,   done_seen_d;
  logic             we_q,          we_d;
  logic [DEPTH-1:0] a_q,           a_d;
  logic [WIDTH-1:0] di_q,          di_d;
  logic             frame_done_q,  frame_done_d;
  logic             short_frame_q, short_frame_d;
  logic             overrun_q,     overrun_d;

  // Per-cycle pixel placement, chosen by the state logic and applied once.
  logic             take_pixel;
  logic [LW-1:0]    lane;
  logic [DEPTH-1:0] word;

  logic start_ok;
  logic clear_ok;

  assign start_ok = enable & frame_start;
  // frame_start wins a tie with clear_req.
  assign clear_ok = enable & clear_req & ~frame_start;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    pixcnt_d      = pixcnt_q;
    pack_d        = pack_q;
    clear_val_d   = clear_val_q;
    done_seen_d   = done_seen_q;
    we_d          = 1'b0;
    a_d           = a_q;
    di_d          = di_q;
    frame_done_d  = 1'b0;
    short_frame_d = 1'b0;
    overrun_d     = overrun_q;
    take_pixel    = 1'b0;
    lane          = pixcnt_q;
    word          = wcnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = CAPTURE;
          overrun_d   = 1'b0;
          done_seen_d = 1'b0;
          wcnt_d      = '0;
          pixcnt_d    = '0;
          lane        = '0;
          word        = '0;
          take_pixel  = pix_valid;
        end else if (clear_ok) begin
          // The first fill write goes out in the cycle after acceptance.
          state_d     = CLEAR;
          clear_val_d = clear_val;
          wcnt_d      = '0;
          we_d        = 1'b1;
          a_d         = '0;
          di_d        = {LANES{clear_val}};
        end else if (pix_valid && done_seen_q) begin
          overrun_d = 1'b1;
        end
      end

      CAPTURE: begin
        if (frame_done_q) begin
          // The final write is on the bus; the frame is already complete, so
          // a new start is a clean restart rather than an abort.
          if (start_ok) begin
            overrun_d   = 1'b0;
            done_seen_d = 1'b0;
            wcnt_d      = '0;
            pixcnt_d    = '0;
            lane        = '0;
            word        = '0;
            take_pixel  = pix_valid;
          end else begin
            state_d = IDLE;
            if (pix_valid) begin
              overrun_d = 1'b1;
            end
          end
        end else if (start_ok) begin
          // Abort: the partial word is simply never written.
          short_frame_d = 1'b1;
          wcnt_d        = '0;
          pixcnt_d      = '0;
          lane          = '0;
          word          = '0;
          take_pixel    = pix_valid;
        end else begin
          take_pixel = pix_valid;
        end
      end

      CLEAR: begin
        // wcnt_q holds the address written in the current cycle.
        if (wcnt_q == LAST_WORD) begin
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          we_d   = 1'b1;
          a_d    = wcnt_q + 1'b1;
          di_d   = {LANES{clear_val_q}};
        end
      end

      default: state_d = IDLE;
    endcase

    if (take_pixel) begin
      pack_d[lane*PIX_W +: PIX_W] = pix_data;
      pixcnt_d = lane + 1'b1;
      if (lane == LAST_LANE) begin
        we_d = 1'b1;
        a_d  = word;
        di_d = pack_d;
        if (word == LAST_WORD) begin
          frame_done_d = 1'b1;
          done_seen_d  = 1'b1;
        end else begin
          wcnt_d = word + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      pixcnt_q      <= '0;
      // NOTE: the pack register is reset too, so di can never carry X even
      // though it is don't-care while we is low.
      pack_q        <= '0;
      clear_val_q   <= '0;
      done_seen_q   <= 1'b0;
      we_q          <= 1'b0;
      a_q           <= '0;
      di_q          <= '0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      pixcnt_q      <= pixcnt_d;
      pack_q        <= pack_d;
      clear_val_q   <= clear_val_d;
      done_seen_q   <= done_seen_d;
      we_q          <= we_d;
      a_q           <= a_d;
      di_q          <= di_d;
      frame_done_q  <= frame_done_d;
      short_frame_q <= short_frame_d;
      overrun_q     <= overrun_d;
    end
  end

  assign we          = we_q;
  assign a           = a_q;
  assign di          = di_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;
  assign overrun     = overrun_q;

endmodule
